// File: rtl/mac32_result_checker_if.sv
// mac32_result_checker_if
//   Expected-result / DUT-result bus seen by the MAC32 result checker.
//   master : stimulus side (reference model + DUT under test)
//   slave  : the checker
//   Signals:
//     exp_valid_i / exp_i : push one expected result into the checker queue
//     exp_ready_o         : checker can accept a push (queue not full, not done)
//     res_valid_i / res_i : DUT result to compare against the queue head
interface mac32_result_checker_if #(
    parameter int PARM_XLEN = 32
);
    logic                 exp_valid_i;
    logic [PARM_XLEN-1:0] exp_i;
    logic                 exp_ready_o;
    logic                 res_valid_i;
    logic [PARM_XLEN-1:0] res_i;

    modport master (
        output exp_valid_i, exp_i, res_valid_i, res_i,
        input  exp_ready_o
    );

    modport slave (
        input  exp_valid_i, exp_i, res_valid_i, res_i,
        output exp_ready_o
    );
endinterface

// File: rtl/mac32_result_checker.sv
// mac32_result_checker
//   Scoreboard for a single-precision MAC: expected results are queued in
//   order, each DUT result pops the head and is compared to it.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     bus (slave)       : exp push handshake and DUT result (see interface)
//     sim_end_i         : one-cycle pulse, stimulus finished
//     mismatch_o        : one-cycle pulse per failed compare
//     pass_cnt_o/fail_cnt_o : saturating 16-bit compare counters
//     overflow_o/underflow_o/timeout_o : sticky error flags
//     busy_o/chk_done_o : ACTIVE|DRAIN / DONE status
//   Build option:
//     MAC32_CHK_ULP_EN  : same-sign non-NaN results pass within ULP_TOL ULPs;
//                         when undefined they must match bit-exactly.
module mac32_result_checker #(
    parameter int PARM_XLEN  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ULP_TOL    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mac32_result_checker_if.slave  bus,
    input  logic                   sim_end_i,
    output logic                   mismatch_o,
    output logic [15:0]            pass_cnt_o,
    output logic [15:0]            fail_cnt_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   timeout_o,
    output logic                   busy_o,
    output logic                   chk_done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // 64 idle DRAIN cycles before giving up on outstanding results
    localparam logic [5:0] TMO_LAST = 6'd63;

`ifdef MAC32_CHK_ULP_EN
    localparam int unsigned EFF_TOL = ULP_TOL;
`else
    // Bit-exact mode: zero tolerance (product keeps ULP_TOL referenced)
    localparam int unsigned EFF_TOL = 0 * ULP_TOL;
`endif
    localparam logic [30:0] TOL = 31'(EFF_TOL);

    logic [1:0]           state, state_nxt;
    logic [PARM_XLEN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [5:0]           tmo_cnt;

    logic full, pop, push_ok, push_drop;
    logic res_pass, res_fail, tmo_expire;
    logic [CW-1:0] fail_inc;
    logic [16:0]   fail_sum;

    // ---------------- compare ----------------
    logic [PARM_XLEN-1:0] head;
    logic [30:0]          e_mag, r_mag, mag_diff;
    logic                 e_nan, r_nan, cmp_ok;

    assign head     = mem[rd_ptr];
    assign e_mag    = head[30:0];
    assign r_mag    = bus.res_i[30:0];
    assign e_nan    = (e_mag[30:23] == 8'hFF) && (e_mag[22:0] != 23'd0);
    assign r_nan    = (r_mag[30:23] == 8'hFF) && (r_mag[22:0] != 23'd0);
    // Magnitude fields order like integers, so Inf vs max-normal is 1 apart
    assign mag_diff = (r_mag >= e_mag) ? (r_mag - e_mag) : (e_mag - r_mag);

    always_comb begin
        cmp_ok = 1'b0;
        if (e_nan && r_nan)
            cmp_ok = 1'b1;
        else if (e_nan || r_nan)
            cmp_ok = 1'b0;
        else if ((e_mag == 31'd0) && (r_mag == 31'd0))
            cmp_ok = 1'b1;                      // +0 == -0
        else if (head[31] != bus.res_i[31])
            cmp_ok = 1'b0;
        else
            cmp_ok = (mag_diff <= TOL);
    end

    // ---------------- queue control ----------------
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = bus.res_valid_i && (count != '0);
    assign tmo_expire = (state == S_DRAIN) && !pop && (count != '0) &&
                        (tmo_cnt == TMO_LAST);
    // Pop frees a slot in the same cycle, so push+pop at full both succeed.
    // Nothing is accepted in the flush cycle or once DONE.
    assign push_ok    = bus.exp_valid_i && (state != S_DONE) && !tmo_expire &&
                        (!full || pop);
    assign push_drop  = bus.exp_valid_i && !push_ok;

    assign res_pass   = pop && cmp_ok;
    assign res_fail   = bus.res_valid_i && !(pop && cmp_ok);

    // A flush happens only in a cycle with no pop, so the two never combine
    assign fail_inc   = tmo_expire ? count : CW'(res_fail);
    assign fail_sum   = {1'b0, fail_cnt_o} + 17'(fail_inc);

    // ---------------- FSM ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (push_ok)
                    state_nxt = sim_end_i ? S_DRAIN : S_ACTIVE;
                else if (sim_end_i)
                    state_nxt = S_DONE;
            end
            S_ACTIVE: begin
                if (sim_end_i)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (tmo_expire || ((count == '0) && !push_ok))
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_DONE;
        endcase
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tmo_cnt     <= '0;
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            mismatch_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            mismatch_o <= res_fail;

            if (res_pass && (pass_cnt_o != 16'hFFFF))
                pass_cnt_o <= pass_cnt_o + 16'd1;
            if (fail_inc != '0)
                fail_cnt_o <= fail_sum[16] ? 16'hFFFF : fail_sum[15:0];

            if (push_drop)                   overflow_o  <= 1'b1;
            if (bus.res_valid_i && !pop)     underflow_o <= 1'b1;
            if (tmo_expire)                  timeout_o   <= 1'b1;

            if (tmo_expire) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push_ok) - CW'(pop);
            end

            // Timer restarts on entry to DRAIN and on every pop
            if ((state != S_DRAIN) || pop)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 6'd1;
        end
    end

    // Storage needs no reset: pointers/count define what is valid
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.exp_i;
    end

    assign bus.exp_ready_o = !full && (state != S_DONE);
    assign busy_o          = (state == S_ACTIVE) || (state == S_DRAIN);
    assign chk_done_o      = (state == S_DONE);

endmodule

// File: tb/tb_mac32_result_checker.sv
// tb_mac32_result_checker
//   Directed bench for mac32_result_checker: reset values, pass/fail
//   compares (NaN, signed zero, ULP window, Inf vs max-normal), underflow,
//   full-queue overflow and push+pop at full, DRAIN timeout, async reset
//   mid-run and sim_end in IDLE.
module tb_mac32_result_checker;
    logic        clk;
    logic        rst_n;
    logic        sim_end_i;
    logic        mismatch_o;
    logic [15:0] pass_cnt_o, fail_cnt_o;
    logic        overflow_o, underflow_o, timeout_o, busy_o, chk_done_o;

`ifdef MAC32_CHK_ULP_EN
    localparam bit ULP_EN = 1'b1;
`else
    localparam bit ULP_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int ep, ef, n;

    mac32_result_checker_if #(.PARM_XLEN(32)) bus ();

    mac32_result_checker #(
        .PARM_XLEN (32),
        .FIFO_DEPTH(8),
        .ULP_TOL   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sim_end_i  (sim_end_i),
        .mismatch_o (mismatch_o),
        .pass_cnt_o (pass_cnt_o),
        .fail_cnt_o (fail_cnt_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o),
        .timeout_o  (timeout_o),
        .busy_o     (busy_o),
        .chk_done_o (chk_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        bus.exp_valid_i = 1'b1;
        bus.exp_i       = v;
        tick();
        bus.exp_valid_i = 1'b0;
    endtask

    task automatic result(input logic [31:0] v);
        bus.res_valid_i = 1'b1;
        bus.res_i       = v;
        tick();
        bus.res_valid_i = 1'b0;
    endtask

    task automatic end_pulse();
        sim_end_i = 1'b1;
        tick();
        sim_end_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.exp_valid_i = 1'b0;
        bus.exp_i       = '0;
        bus.res_valid_i = 1'b0;
        bus.res_i       = '0;
        sim_end_i       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset values ----
        do_reset();
        chk("rst_ready", 32'(bus.exp_ready_o), 1);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_done",  32'(chk_done_o), 0);
        chk("rst_pass",  32'(pass_cnt_o), 0);
        chk("rst_fail",  32'(fail_cnt_o), 0);
        chk("rst_flags", 32'({mismatch_o, overflow_o, underflow_o, timeout_o}), 0);

        // ---- exact match ----
        push(32'h40F00000);
        chk("idle_to_active", 32'(busy_o), 1);
        result(32'h40F00000);
        chk("exact_pass", 32'(pass_cnt_o), 1);
        chk("exact_nomis", 32'(mismatch_o), 0);
        tick();
        chk("exact_nomis2", 32'(mismatch_o), 0);

        // ---- NaN handling ----
        push(32'h7FC00000);
        result(32'h7FA00000);
        chk("nan_nan_pass", 32'(pass_cnt_o), 2);
        chk("nan_nan_fail", 32'(fail_cnt_o), 0);
        push(32'h3F800000);
        result(32'h7FC00000);
        chk("one_nan_fail", 32'(fail_cnt_o), 1);
        chk("one_nan_mis", 32'(mismatch_o), 1);
        tick();
        chk("mis_one_pulse", 32'(mismatch_o), 0);
        ep = 2; ef = 1;

        // ---- tolerance window ----
        push(32'h3F800000);
        result(32'h3F800002);
        if (ULP_EN) ep++; else ef++;
        chk("ulp2_pass", 32'(pass_cnt_o), 32'(ep));
        chk("ulp2_fail", 32'(fail_cnt_o), 32'(ef));
        push(32'h3F800000);
        result(32'h3F800003);
        ef++;
        chk("ulp3_fail", 32'(fail_cnt_o), 32'(ef));
        push(32'h00000000);
        result(32'h80000000);
        ep++;
        chk("zero_sign_pass", 32'(pass_cnt_o), 32'(ep));
        push(32'h7F7FFFFF);
        result(32'h7F800000);
        if (ULP_EN) ep++; else ef++;
        chk("inf_maxn_pass", 32'(pass_cnt_o), 32'(ep));
        chk("inf_maxn_fail", 32'(fail_cnt_o), 32'(ef));
        push(32'h3F800000);
        result(32'hBF800000);
        ef++;
        chk("sign_fail", 32'(fail_cnt_o), 32'(ef));
        chk("sign_mis", 32'(mismatch_o), 1);

        // ---- underflow ----
        chk("uf_clear", 32'(underflow_o), 0);
        result(32'h40000000);
        ef++;
        chk("uf_set", 32'(underflow_o), 1);
        chk("uf_fail", 32'(fail_cnt_o), 32'(ef));
        chk("uf_mis", 32'(mismatch_o), 1);

        // ---- sim_end with empty queue: DRAIN then DONE ----
        end_pulse();
        chk("drain_busy", 32'(busy_o), 1);
        tick();
        chk("done_flag", 32'(chk_done_o), 1);
        chk("done_busy", 32'(busy_o), 0);
        chk("done_ready", 32'(bus.exp_ready_o), 0);
        chk("done_ovf0", 32'(overflow_o), 0);
        push(32'h12345678);
        chk("done_push_ovf", 32'(overflow_o), 1);
        result(32'h12345678);
        ef++;
        chk("done_res_fail", 32'(fail_cnt_o), 32'(ef));
        chk("done_pass_held", 32'(pass_cnt_o), 32'(ep));

        // ---- full queue ----
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
        chk("full_ready", 32'(bus.exp_ready_o), 0);
        chk("full_ovf0", 32'(overflow_o), 0);
        push(32'h108);
        chk("full_ovf1", 32'(overflow_o), 1);
        bus.exp_valid_i = 1'b1; bus.exp_i = 32'h200;
        bus.res_valid_i = 1'b1; bus.res_i = 32'h100;
        tick();
        bus.exp_valid_i = 1'b0; bus.res_valid_i = 1'b0;
        chk("pp_still_full", 32'(bus.exp_ready_o), 0);
        chk("pp_pass", 32'(pass_cnt_o), 1);
        for (int i = 1; i < 8; i++) result(32'h100 + 32'(i));
        result(32'h200);
        chk("drain8_pass", 32'(pass_cnt_o), 9);
        chk("drain8_fail", 32'(fail_cnt_o), 0);
        chk("drain8_ready", 32'(bus.exp_ready_o), 1);
        chk("drain8_uf0", 32'(underflow_o), 0);
        result(32'h108);
        chk("dropped_uf", 32'(underflow_o), 1);
        chk("dropped_fail", 32'(fail_cnt_o), 1);

        // ---- DRAIN timeout ----
        do_reset();
        push(32'h1); push(32'h2); push(32'h3);
        end_pulse();
        result(32'h1);
        chk("tmo_pass", 32'(pass_cnt_o), 1);
        n = 0;
        while (!chk_done_o && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 32'(n), 64);
        chk("tmo_flag", 32'(timeout_o), 1);
        chk("tmo_fail", 32'(fail_cnt_o), 2);
        chk("tmo_busy", 32'(busy_o), 0);

        // ---- async reset mid-ACTIVE ----
        do_reset();
        result(32'h5);
        for (int i = 0; i < 5; i++) push(32'h3F800000);
        chk("pre_rst_busy", 32'(busy_o), 1);
        chk("pre_rst_fail", 32'(fail_cnt_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.exp_ready_o), 1);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_done", 32'(chk_done_o), 0);
        chk("arst_cnts", 32'({pass_cnt_o, fail_cnt_o}), 0);
        chk("arst_flags", 32'({mismatch_o, overflow_o, underflow_o, timeout_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        result(32'h3F800000);
        chk("arst_uf", 32'(underflow_o), 1);
        chk("arst_uf_fail", 32'(fail_cnt_o), 1);
        chk("arst_uf_pass", 32'(pass_cnt_o), 0);

        // ---- sim_end in IDLE ----
        do_reset();
        end_pulse();
        chk("idle_end_done", 32'(chk_done_o), 1);
        chk("idle_end_busy", 32'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
